// File: rtl/logic_eval_pkg.sv
// Shared definitions for the logic evaluation pipeline: operation encodings
// used by the per-channel evaluator and by anything that drives in_op.
package logic_eval_pkg;

  typedef enum logic [1:0] {
    OP_AND_OR = 2'b00,
    OP_OR_AND = 2'b01,
    OP_MAJ    = 2'b10,
    OP_XOR3   = 2'b11
  } op_e;

endpackage

// File: rtl/logic_eval_op.sv
// Purely combinational bitwise three-operand evaluator for one channel.
module logic_eval_op
  import logic_eval_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_AND_OR: y_o = a_i & (b_i | c_i);
      OP_OR_AND: y_o = a_i | (b_i & c_i);
      OP_MAJ:    y_o = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);
      OP_XOR3:   y_o = a_i ^ b_i ^ c_i;
      default:   y_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_eval_pipe.sv
// Two-stage valid/ready pipeline evaluating a bitwise op on every channel,
// with per-channel non-zero flags, their popcount and a saturating hit counter.
module logic_eval_pipe
  import logic_eval_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [CHANNELS*WIDTH-1:0]         in_a,
  input  logic [CHANNELS*WIDTH-1:0]         in_b,
  input  logic [CHANNELS*WIDTH-1:0]         in_c,
  input  logic [1:0]                        in_op,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CHANNELS*WIDTH-1:0]         out_result,
  output logic [CHANNELS-1:0]               out_nz,
  output logic [$clog2(CHANNELS+1)-1:0]     out_nz_cnt,
  output logic [CNT_W-1:0]                  hit_cnt,
  input  logic                              cnt_clr
);

  localparam int DW  = CHANNELS * WIDTH;
  localparam int NZW = $clog2(CHANNELS + 1);

  logic [DW-1:0]    opResult;
  logic             readyEn_q;
  logic             s1Valid_q, s1Valid_d;
  logic [DW-1:0]    s1Data_q, s1Data_d;
  logic             s2Valid_q, s2Valid_d;
  logic [DW-1:0]    result_q, result_d;
  logic [CHANNELS-1:0] nz_q, nz_d;
  logic [NZW-1:0]   nzCnt_q, nzCnt_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CHANNELS-1:0] s1Nz;
  logic [NZW-1:0]   s1NzCnt;
  logic             s1Move, s1Free, accept, s2Load, deliver;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    logic_eval_op #(.WIDTH(WIDTH)) u_op (
      .a_i (in_a[ch*WIDTH +: WIDTH]),
      .b_i (in_b[ch*WIDTH +: WIDTH]),
      .c_i (in_c[ch*WIDTH +: WIDTH]),
      .op_i(in_op),
      .y_o (opResult[ch*WIDTH +: WIDTH])
    );
  end

  // readyEn_q keeps in_ready low through reset and for the release cycle.
  assign s1Move   = !s2Valid_q || out_ready;
  assign s1Free   = !s1Valid_q || s1Move;
  assign in_ready = readyEn_q && s1Free;
  assign accept   = in_valid && in_ready;
  assign s2Load   = s1Valid_q && s1Move;
  assign deliver  = s2Valid_q && out_ready;

  always_comb begin
    s1Nz    = '0;
    s1NzCnt = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      s1Nz[k] = |s1Data_q[k*WIDTH +: WIDTH];
      s1NzCnt = s1NzCnt + NZW'(s1Nz[k]);
    end
  end

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Data_d  = s1Data_q;
    s2Valid_d = s2Valid_q;
    result_d  = result_q;
    nz_d      = nz_q;
    nzCnt_d   = nzCnt_q;
    hit_d     = hit_q;
    if (s1Free) s1Valid_d = accept;
    if (accept) s1Data_d = opResult;
    if (s1Move) s2Valid_d = s1Valid_q;
    if (s2Load) begin
      result_d = s1Data_q;
      nz_d     = s1Nz;
      nzCnt_d  = s1NzCnt;
    end
    // Clear wins over a same-cycle hit; the counter sticks at all-ones.
    if (cnt_clr) hit_d = '0;
    else if (deliver && (|nz_q) && (hit_q != '1)) hit_d = hit_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readyEn_q <= 1'b0;
      s1Valid_q <= 1'b0;
      s1Data_q  <= '0;
      s2Valid_q <= 1'b0;
      result_q  <= '0;
      nz_q      <= '0;
      nzCnt_q   <= '0;
      hit_q     <= '0;
    end else begin
      readyEn_q <= 1'b1;
      s1Valid_q <= s1Valid_d;
      s1Data_q  <= s1Data_d;
      s2Valid_q <= s2Valid_d;
      result_q  <= result_d;
      nz_q      <= nz_d;
      nzCnt_q   <= nzCnt_d;
      hit_q     <= hit_d;
    end
  end

  assign out_valid  = s2Valid_q;
  assign out_result = result_q;
  assign out_nz     = nz_q;
  assign out_nz_cnt = nzCnt_q;
  assign hit_cnt    = hit_q;

endmodule

// File: tb/tb_logic_eval_pipe.sv
// Scoreboard bench for logic_eval_pipe: stimulus pushes model results into a
// queue, an independent monitor pops them whenever a result beat is delivered.
module tb_logic_eval_pipe;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int CNT_W    = 4;
  localparam int DW       = WIDTH * CHANNELS;

  typedef struct {
    logic [DW-1:0]       res;
    logic [CHANNELS-1:0] nz;
    logic [2:0]          cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_a, in_b, in_c;
  logic [1:0]        in_op;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_result;
  logic [CHANNELS-1:0] out_nz;
  logic [2:0]        out_nz_cnt;
  logic [CNT_W-1:0]  hit_cnt;
  logic              cnt_clr;

  exp_t   sb[$];
  int     nVec = 0;
  int     nFail = 0;
  int     modelHit = 0;
  int     readyMode = 0;
  bit     stallPrev = 0;
  logic [DW+CHANNELS+2:0] stallData;
  bit     watchReady = 0;
  bit     sawReadyLow = 0;

  logic_eval_pipe #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_nz(out_nz), .out_nz_cnt(out_nz_cnt), .hit_cnt(hit_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  // Bit-level reference: each result bit is decided by how many inputs are set.
  function automatic logic [WIDTH-1:0] refChan(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                               logic [WIDTH-1:0] c, logic [1:0] op);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      int bc;
      int ones;
      bc   = int'(b[i]) + int'(c[i]);
      ones = int'(a[i]) + bc;
      case (op)
        2'd0:    r[i] = a[i] && (bc > 0);
        2'd1:    r[i] = a[i] || (bc == 2);
        2'd2:    r[i] = (ones >= 2);
        default: r[i] = (ones % 2) == 1;
      endcase
    end
    return r;
  endfunction

  function automatic exp_t model(logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] c,
                                 logic [1:0] op);
    exp_t e;
    int   n;
    n = 0;
    e.res = '0;
    e.nz  = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      e.res[ch*WIDTH +: WIDTH] = refChan(a[ch*WIDTH +: WIDTH], b[ch*WIDTH +: WIDTH],
                                         c[ch*WIDTH +: WIDTH], op);
      e.nz[ch] = (e.res[ch*WIDTH +: WIDTH] != 0);
      if (e.nz[ch]) n++;
    end
    e.cnt = 3'(n);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic failNote(input string name);
    nVec++;
    nFail++;
    $display("[TB] FAIL %s (t=%0t)", name, $time);
  endtask

  // Offer one beat; returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [DW-1:0] c, input logic [1:0] op);
    int waitCyc;
    waitCyc  = 0;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    in_op    = op;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waitCyc < 100) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!in_ready) failNote("accept_timeout");
    else sb.push_back(model(a, b, c, op));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) failNote("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // Empty pipe, out_ready high: result must appear on the second edge.
  task automatic latencyCheck(input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [DW-1:0] c, input logic [1:0] op,
                              input logic [DW-1:0] expRes, input logic [CHANNELS-1:0] expNz,
                              input logic [2:0] expCnt);
    applyStimulus(a, b, c, op);
    checkOutput("lat_not_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_valid", 64'(out_valid), 64'd1);
    checkOutput("lat_result", 64'(out_result), 64'(expRes));
    checkOutput("lat_nz", 64'(out_nz), 64'(expNz));
    checkOutput("lat_nz_cnt", 64'(out_nz_cnt), 64'(expCnt));
    waitDrain();
  endtask

  // out_ready driver for free-running modes; mode 3 leaves it to the main flow.
  always @(posedge clk) begin
    #1;
    if (readyMode == 0) out_ready = 1'b1;
    else if (readyMode == 1) out_ready = 1'($urandom);
  end

  // Monitor: delivered beats, hold-stability under backpressure, hit counter.
  always @(negedge clk) begin
    exp_t e;
    bit   delivered;
    bit   hitNow;
    delivered = 0;
    hitNow    = 0;
    if (rst) begin
      modelHit  = 0;
      stallPrev = 0;
    end else begin
      checkOutput("hit_cnt", 64'(hit_cnt), 64'(modelHit));
      if (stallPrev) begin
        checkOutput("stall_valid", 64'(out_valid), 64'd1);
        checkOutput("stall_data", 64'({out_result, out_nz, out_nz_cnt}), 64'(stallData));
      end
      if (out_valid && out_ready) begin
        delivered = 1;
        if (sb.size() == 0) begin
          failNote("unexpected_beat");
        end else begin
          e = sb.pop_front();
          checkOutput("out_result", 64'(out_result), 64'(e.res));
          checkOutput("out_nz", 64'(out_nz), 64'(e.nz));
          checkOutput("out_nz_cnt", 64'(out_nz_cnt), 64'(e.cnt));
          hitNow = (e.nz != 0);
        end
      end
      if (cnt_clr) modelHit = 0;
      else if (delivered && hitNow && modelHit < (1 << CNT_W) - 1) modelHit++;
      stallPrev = out_valid && !out_ready;
      stallData = {out_result, out_nz, out_nz_cnt};
      if (watchReady && !in_ready) sawReadyLow = 1;
    end
  end

  initial begin
    logic [DW-1:0] a, b, c;
    int waitCyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_c      = '0;
    in_op     = '0;
    cnt_clr   = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_result", 64'(out_result), 64'd0);
    checkOutput("rst_out_nz", 64'(out_nz), 64'd0);
    checkOutput("rst_out_nz_cnt", 64'(out_nz_cnt), 64'd0);
    checkOutput("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("release_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("release_in_ready_high", 64'(in_ready), 64'd1);

    $display("[TB] basic evaluation");
    latencyCheck({4{8'hFF}}, {4{8'h0F}}, {4{8'hF0}}, 2'b00, {4{8'hFF}}, 4'hF, 3'd4);
    checkOutput("hit_after_basic", 64'(hit_cnt), 64'd1);

    $display("[TB] majority with zero channels");
    latencyCheck({24'h0, 8'hAA}, {24'h0, 8'h55}, {24'h0, 8'hFF}, 2'b10,
                 {24'h0, 8'hFF}, 4'b0001, 3'd1);
    checkOutput("hit_after_maj", 64'(hit_cnt), 64'd2);

    $display("[TB] xor3");
    latencyCheck({4{8'h0F}}, {4{8'h33}}, {4{8'h55}}, 2'b11, {4{8'h69}}, 4'hF, 3'd4);
    checkOutput("hit_after_xor", 64'(hit_cnt), 64'd3);

    $display("[TB] backpressure");
    readyMode  = 3;
    out_ready  = 1'b1;
    watchReady = 1;
    for (int i = 0; i < 2; i++)
      applyStimulus(DW'($urandom), DW'($urandom), DW'($urandom), 2'($urandom));
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++)
          applyStimulus(DW'($urandom), DW'($urandom), DW'($urandom), 2'($urandom));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain();
    watchReady = 0;
    checkOutput("bp_in_ready_fell", 64'(sawReadyLow), 64'd1);
    readyMode = 0;

    $display("[TB] randomized ops");
    readyMode = 1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      a = DW'($urandom);
      b = DW'($urandom);
      c = DW'($urandom);
      if ($urandom_range(0, 3) == 0) a = '0;
      applyStimulus(a, b, c, 2'($urandom));
    end
    readyMode = 0;
    waitDrain();

    $display("[TB] saturation");
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    checkOutput("hit_cleared", 64'(hit_cnt), 64'd0);
    for (int i = 0; i < 20; i++)
      applyStimulus(DW'($urandom) | DW'(1), DW'($urandom), DW'($urandom), 2'b01);
    waitDrain();
    checkOutput("hit_saturated", 64'(hit_cnt), 64'd15);

    $display("[TB] clear priority");
    readyMode = 3;
    out_ready = 1'b0;
    applyStimulus({4{8'hFF}}, {4{8'h00}}, {4{8'h00}}, 2'b01);
    waitCyc = 0;
    while (!out_valid && waitCyc < 20) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!out_valid) failNote("clr_wait_timeout");
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    checkOutput("hit_clr_priority", 64'(hit_cnt), 64'd0);
    checkOutput("clr_beat_gone", 64'(out_valid), 64'd0);
    readyMode = 0;
    waitDrain();

    $display("[TB] reset mid-operation");
    readyMode = 3;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++)
      applyStimulus(DW'($urandom) | DW'(1), DW'($urandom), DW'($urandom), 2'b01);
    rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("midrst_out_result", 64'(out_result), 64'd0);
    checkOutput("midrst_hit_cnt", 64'(hit_cnt), 64'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkOutput("no_stale_beat", 64'(out_valid), 64'd0);
    end
    readyMode = 0;
    latencyCheck({4{8'h0F}}, {4{8'h33}}, {4{8'h55}}, 2'b11, {4{8'h69}}, 4'hF, 3'd4);
    checkOutput("hit_after_reset_beat", 64'(hit_cnt), 64'd1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/logic_eval_pipe.md
LOGIC_EVAL_PIPE -- requirements
Module: logic_eval_pipe

Interface
REQ-001 SHALL have parameter WIDTH, 8: bit width of each channel operand.
REQ-002 SHALL have parameter CHANNELS, 4: number of independent operand channels, range 1..16.
REQ-003 SHALL have parameter CNT_W, 16: width of the hit counter.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operand beat valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-008 SHALL have port in_a, input, CHANNELS*WIDTH bits: operand A; channel k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have ports in_b and in_c, input, CHANNELS*WIDTH bits each: operands B and C, packed the same way as in_a.
REQ-010 SHALL have port in_op, input, 2 bits: operation, sampled with the beat.
REQ-011 SHALL have port out_valid, output, 1 bit: result beat valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result beat.
REQ-013 SHALL have port out_result, output, CHANNELS*WIDTH bits: per-channel result.
REQ-014 SHALL have port out_nz, output, CHANNELS bits: bit k is the OR-reduction of channel k's result.
REQ-015 SHALL have port out_nz_cnt, output, $clog2(CHANNELS+1) bits: population count of out_nz.
REQ-016 SHALL have port hit_cnt, output, CNT_W bits: saturating count of delivered beats with any out_nz bit set.
REQ-017 SHALL have port cnt_clr, input, 1 bit: synchronous clear of hit_cnt.

Function
REQ-018 SHALL compute each bit of each channel according to in_op:
- 00: A&(B|C).
- 01: A|(B&C).
- 10: majority, AB|BC|AC.
- 11: A^B^C.
REQ-019 SHALL be a two-stage pipeline:
- stage 1 registers the per-channel result.
- stage 2 registers out_result, out_nz and out_nz_cnt.
- Latency is 2 cycles from acceptance to out_valid when out_ready stays high.
REQ-020 SHALL accept a beat only on in_valid && in_ready, and deliver a result only on out_valid && out_ready.
REQ-021 SHALL drive in_ready = !s1_valid || s1_move, where s1_move = !s2_valid || out_ready; in_ready has no combinational path from in_valid.
REQ-022 SHALL sustain one beat per cycle at full throughput while out_ready is continuously high.
REQ-023 SHALL hold out_valid and all output data stable while out_valid && !out_ready.
REQ-024 SHALL never drop, duplicate or reorder beats; at most 2 beats are in flight.
REQ-025 SHALL increment hit_cnt by 1 on each delivered beat with out_nz != 0, and saturate at all-ones (no wrap).
REQ-026 SHALL give cnt_clr priority over an increment in the same cycle, so hit_cnt becomes 0.
REQ-027 SHALL leave data registers unchanged when no beat moves; stage valid bits alone qualify data.

Reset
REQ-028 SHALL, on rst assertion, immediately force stage-1 and stage-2 valid low, out_valid to 0 and hit_cnt to 0.
REQ-029 SHALL, on rst assertion, set out_result, out_nz and out_nz_cnt to 0.
REQ-030 SHALL discard any in-flight beats when rst is asserted mid-operation.
REQ-031 SHALL hold in_ready at 0 while rst is high and raise it in the first clock after deassertion.

Structure
REQ-032 SHALL place the op encodings (OP_AND_OR, OP_OR_AND, OP_MAJ, OP_XOR3) in shared package logic_eval_pkg.
REQ-033 SHALL implement the per-channel bitwise op evaluation as one combinational sub-module, logic_eval_op, instantiated CHANNELS times.

Verification
REQ-034 SHALL check basic evaluation: with WIDTH=8 and CHANNELS=4, op 00, a=0xFF, b=0x0F, c=0xF0 on all channels -> out_result channel = 0xFF, out_nz=4'hF, out_nz_cnt=4, two cycles after acceptance.
REQ-035 SHALL check majority and zero results: op 10, ch0 a=0xAA, b=0x55, c=0xFF; other channels all zero -> ch0=0xFF, out_nz=4'b0001, out_nz_cnt=1, hit_cnt increments by 1.
REQ-036 SHALL check backpressure: stream 5 beats with out_ready low for 3 cycles mid-stream -> in_ready falls once 2 beats are held, outputs stay stable, all 5 results emerge in order with no loss.
REQ-037 SHALL check saturation and clear priority:
- with CNT_W=4, deliver 20 hit beats -> hit_cnt holds 15.
- assert cnt_clr together with a hit delivery -> hit_cnt = 0.
REQ-038 SHALL check reset mid-operation: assert rst with 2 beats in flight -> out_valid drops at once and no stale beat appears after release.
REQ-039 SHALL check op 11: a=0x0F, b=0x33, c=0x55 -> result 0x69, and repeat across all four ops with randomized operands against a bit-level model.
